// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin arbiter feeding one 8N1 UART transmitter.
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       last_grant
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, last_grant_q, last_grant_d;
  logic can_grant, grant, tc;
  always_comb begin
    can_grant = rst_n && ena && state_q == IDLE && (req0_valid || req1_valid);
    grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = can_grant && !grant;
    req1_ready = can_grant && grant;
    tc = cnt_q == CW'(CLKS_PER_BIT - 1);
    state_d = state_q;
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    tx_d = tx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (can_grant) begin
          shift_d = grant ? req1_data : req0_data;
          last_grant_d = grant;
          state_d = START;
          tx_d = 1'b0;
        end
      end
      START: if (tc) begin
        state_d = DATA;
        idx_d = 3'd0;
        tx_d = shift_q[0];
      end
      // the shift register always presents the current bit at [0]
      DATA: if (tc) begin
        idx_d = idx_q + 1'b1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
        tx_d = idx_q == 3'd7 ? 1'b1 : shift_q[1];
        shift_d = shift_q >> 1;
      end
      STOP: if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= 3'd0;
      shift_q <= 8'h00;
      tx_q <= 1'b1;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  assign last_grant = last_grant_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench checking the scheduler against a frame-level reference model.
module tb_uart_tx_sched;
  localparam int C = 4;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic r0v = 1'b0, r1v = 1'b0, r0r, r1r, tx, busy, lg;
  logic [7:0] r0d = 8'h00, r1d = 8'h00;
  always #5 clk = ~clk;

  uart_tx_sched #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
    .tx(tx), .busy(busy), .last_grant(lg)
  );

  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a 10-bit word {stop, data, start} shown C cycles per bit.
  byte unsigned q0[$], q1[$];
  int acc_who[$], acc_cyc[$];
  byte unsigned acc_byte[$];
  int rem = 0, pos = 0, cyc = 0, w, p_n;
  logic [9:0] frame = 10'h3ff;
  logic m_lg = 1'b1;

  function automatic int pick();
    if (!rst_n || !ena || rem > 0 || !(r0v || r1v)) return -1;
    if (r0v && r1v) return m_lg ? 0 : 1;
    return r1v ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0;
      pos = 0;
      m_lg = 1'b1;
    end else begin
      cyc++;
      if (rem > 0) begin
        rem--;
        pos++;
      end else begin
        w = pick();
        if (w >= 0) begin
          frame = {1'b1, (w == 1) ? r1d : r0d, 1'b0};
          rem = 10 * C;
          pos = 0;
          m_lg = w[0];
          acc_who.push_back(w);
          acc_byte.push_back((w == 1) ? r1d : r0d);
          acc_cyc.push_back(cyc);
          if (w == 1) void'(q1.pop_front()); else void'(q0.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    p_n = pick();
    check("req0_ready", 32'(r0r), 32'(p_n == 0));
    check("req1_ready", 32'(r1r), 32'(p_n == 1));
    check("tx", 32'(tx), 32'(rem > 0 ? frame[pos / C] : 1'b1));
    check("busy", 32'(busy), 32'(rem > 0));
    check("last_grant", 32'(lg), 32'(m_lg));
    r0v = q0.size() > 0;
    r0d = r0v ? q0[0] : 8'h00;
    r1v = q1.size() > 0;
    r1d = r1v ? q1[0] : 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_byte.size() < n && b < 2000) begin
      tick(1);
      b++;
    end
    if (acc_byte.size() < n) check("acc_timeout", 32'(acc_byte.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((rem > 0 || q0.size() > 0 || q1.size() > 0) && b < 20000) begin
      tick(1);
      b++;
    end
    check("idle_timeout", 32'(rem > 0 || q0.size() > 0 || q1.size() > 0), 32'(0));
    tick(2);
  endtask

  task automatic do_reset();
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  int base;
  initial begin
    tick(3);
    check("reset_tx", 32'(tx), 32'(1));
    check("reset_lg", 32'(lg), 32'(1));
    rst_n = 1'b1;
    ena = 1'b1;
    // single 0xA5 from req0
    base = acc_byte.size();
    q0.push_back(8'hA5);
    wait_acc(base + 1);
    wait_idle();
    check("a5_byte", 32'(acc_byte[base]), 32'h A5);
    check("a5_who", 32'(acc_who[base]), 32'(0));
    // both valid right after reset: req0 first, 41 cycles apart
    do_reset();
    base = acc_byte.size();
    q0.push_back(8'h55);
    q1.push_back(8'h0F);
    wait_acc(base + 2);
    wait_idle();
    check("pair_first", 32'(acc_byte[base]), 32'h55);
    check("pair_second", 32'(acc_byte[base + 1]), 32'h0F);
    check("pair_spacing", 32'(acc_cyc[base + 1] - acc_cyc[base]), 32'(10 * C + 1));
    // continuous contention alternates
    base = acc_byte.size();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
    end
    wait_acc(base + 4);
    wait_idle();
    for (int i = 0; i < 4; i++) check("alternate", 32'(acc_who[base + i]), 32'(i % 2));
    // ena low blocks grants; dropping ena mid-frame leaves the frame intact
    ena = 1'b0;
    base = acc_byte.size();
    q1.push_back(8'hFF);
    tick(100);
    check("ena_block", 32'(acc_byte.size()), 32'(base));
    ena = 1'b1;
    wait_acc(base + 1);
    ena = 1'b0;
    q0.push_back(8'h12);
    tick(50);
    check("ena_frame", 32'(acc_byte[base]), 32'hFF);
    check("ena_no_more", 32'(acc_byte.size()), 32'(base + 1));
    ena = 1'b1;
    wait_idle();
    // async reset mid-DATA
    base = acc_byte.size();
    q1.push_back(8'h3C);
    wait_acc(base + 1);
    tick(15);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'(1));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_ready", 32'({r0r, r1r}), 32'(0));
    tick(1);
    rst_n = 1'b1;
    base = acc_byte.size();
    q0.push_back(8'h96);
    q1.push_back(8'h69);
    wait_acc(base + 2);
    wait_idle();
    check("arst_next", 32'(acc_who[base]), 32'(0));
    // req1 only, back-to-back
    base = acc_byte.size();
    q1.push_back(8'h00);
    q1.push_back(8'h80);
    q1.push_back(8'h01);
    wait_acc(base + 3);
    wait_idle();
    for (int i = 0; i < 3; i++) check("r1_only_who", 32'(acc_who[base + i]), 32'(1));
    for (int i = 0; i < 2; i++) check("r1_gap", 32'(acc_cyc[base + i + 1] - acc_cyc[base + i]), 32'(10 * C + 1));
    // random traffic with random ena
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) q0.push_back(8'($urandom));
      if ($urandom_range(0, 2) == 0) q1.push_back(8'($urandom));
      ena = $urandom_range(0, 3) != 0;
      tick($urandom_range(1, 60));
    end
    ena = 1'b1;
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
